// File: rtl/branch_predictor_pkg.sv
// Shared encodings for the fetch-side branch predictor: 2-bit counter states
// and the global conditional-branch type codes used by BranchTypeE.
package branch_predictor_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] CTR_RESET = WNT;
    localparam logic [1:0] CTR_ALLOC = WT;

    typedef enum logic [2:0] {
        NOBRANCH = 3'd0,
        BR_BEQ   = 3'd1,
        BR_BNE   = 3'd2,
        BR_BLT   = 3'd3,
        BR_BGE   = 3'd4,
        BR_BLTU  = 3'd5,
        BR_BGEU  = 3'd6
    } br_type_e;

endpackage

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer: valid/tag/target/2-bit counter per entry.
// Two async read ports (fetch lookup, EX lookup for training), one clocked write port.
module bpu_btb
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] f_idx_i,
    output logic             f_valid_o,
    output logic [TAG_W-1:0] f_tag_o,
    output logic [31:0]      f_target_o,
    output logic [1:0]       f_ctr_o,
    input  logic [IDX_W-1:0] e_idx_i,
    output logic             e_valid_o,
    output logic [TAG_W-1:0] e_tag_o,
    output logic [31:0]      e_target_o,
    output logic [1:0]       e_ctr_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] w_idx_i,
    input  logic             w_valid_i,
    input  logic [TAG_W-1:0] w_tag_i,
    input  logic [31:0]      w_target_i,
    input  logic [1:0]       w_ctr_i
);

    localparam int NUM = 1 << IDX_W;

    logic [NUM-1:0]      valid_q;
    logic [NUM-1:0][1:0] ctr_q;
    logic [TAG_W-1:0]    tag_q    [NUM];
    logic [31:0]         target_q [NUM];

    // Only valid and counter state are reset; tag/target are qualified by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ctr_q   <= {NUM{CTR_RESET}};
        end else if (we_i) begin
            valid_q[w_idx_i] <= w_valid_i;
            ctr_q[w_idx_i]   <= w_ctr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[w_idx_i]    <= w_tag_i;
            target_q[w_idx_i] <= w_target_i;
        end
    end

    assign f_valid_o  = valid_q[f_idx_i];
    assign f_tag_o    = tag_q[f_idx_i];
    assign f_target_o = target_q[f_idx_i];
    assign f_ctr_o    = ctr_q[f_idx_i];

    assign e_valid_o  = valid_q[e_idx_i];
    assign e_tag_o    = tag_q[e_idx_i];
    assign e_target_o = target_q[e_idx_i];
    assign e_ctr_o    = ctr_q[e_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side conditional-branch predictor: IF prediction, EX mispredict/redirect and training.
// Optional statistics counters are enabled with `define BRANCH_PRED_STATS_EN.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        ValidE,
    input  logic [2:0]  BranchTypeE,
    input  logic        BranchE,
    input  logic [31:0] PCE,
    input  logic [31:0] BranchTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredE,
    output logic [31:0] RedirectPCE
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0] BrCountO,
    output logic [31:0] MispredCountO
`endif
);

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_valid, e_valid;
    logic [TAG_W-1:0] f_tag_rd, e_tag_rd;
    logic [31:0]      f_target, e_target;
    logic [1:0]       f_ctr, e_ctr;
    logic             f_hit, e_hit;

    logic             we;
    logic             w_valid;
    logic [TAG_W-1:0] w_tag;
    logic [31:0]      w_target;
    logic [1:0]       w_ctr;

    logic             br;
    logic             mispred;
    logic [31:0]      pc_plus4;
    logic             unused_pc_bits;

    assign f_idx = PCF[IDX_W+1:2];
    assign f_tag = PCF[31:IDX_W+2];
    assign e_idx = PCE[IDX_W+1:2];
    assign e_tag = PCE[31:IDX_W+2];
    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

    bpu_btb #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_idx_i    (f_idx),
        .f_valid_o  (f_valid),
        .f_tag_o    (f_tag_rd),
        .f_target_o (f_target),
        .f_ctr_o    (f_ctr),
        .e_idx_i    (e_idx),
        .e_valid_o  (e_valid),
        .e_tag_o    (e_tag_rd),
        .e_target_o (e_target),
        .e_ctr_o    (e_ctr),
        .we_i       (we),
        .w_idx_i    (e_idx),
        .w_valid_i  (w_valid),
        .w_tag_i    (w_tag),
        .w_target_i (w_target),
        .w_ctr_i    (w_ctr)
    );

    assign f_hit       = f_valid & (f_tag_rd == f_tag);
    assign PredTakenF  = f_hit & f_ctr[1];
    assign PredTargetF = PredTakenF ? f_target : 32'h0;

    assign br       = (BranchTypeE != NOBRANCH);
    assign pc_plus4 = PCE + 32'd4;

    // A taken branch is only correct if it was predicted taken to the right target.
    always_comb begin
        mispred     = 1'b0;
        RedirectPCE = pc_plus4;
        if (br & BranchE & (!PredTakenE | (PredTargetE != BranchTargetE))) begin
            mispred     = 1'b1;
            RedirectPCE = BranchTargetE;
        end else if (PredTakenE & (!br | !BranchE)) begin
            mispred = 1'b1;
        end
    end

    assign MispredE = ValidE & mispred;
    assign e_hit    = e_valid & (e_tag_rd == e_tag);

    always_comb begin
        we       = 1'b0;
        w_valid  = e_valid;
        w_tag    = e_tag_rd;
        w_target = e_target;
        w_ctr    = e_ctr;
        if (ValidE) begin
            if (br & e_hit & BranchE) begin
                we       = 1'b1;
                w_ctr    = sat_inc(e_ctr);
                w_target = BranchTargetE;
            end else if (br & e_hit) begin
                we    = 1'b1;
                w_ctr = sat_dec(e_ctr);
            end else if (br & BranchE) begin
                we       = 1'b1;
                w_valid  = 1'b1;
                w_tag    = e_tag;
                w_target = BranchTargetE;
                w_ctr    = CTR_ALLOC;
            end else if (!br & e_hit) begin
                we      = 1'b1;
                w_valid = 1'b0;
            end
        end
    end

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mis_cnt_q, mis_cnt_d;

    assign br_cnt_d  = br_cnt_q + {31'd0, ValidE & br};
    assign mis_cnt_d = mis_cnt_q + {31'd0, MispredE};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= 32'd0;
            mis_cnt_q <= 32'd0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign BrCountO      = br_cnt_q;
    assign MispredCountO = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios followed by random traffic
// checked against a table-level reference model (honours BRANCH_PRED_STATS_EN).
module tb_branch_predictor;
    import branch_predictor_pkg::*;

    localparam int IDX_W = 6;
    localparam int NUM   = 1 << IDX_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] PCF = '0;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        ValidE = 1'b0;
    logic [2:0]  BranchTypeE = '0;
    logic        BranchE = 1'b0;
    logic [31:0] PCE = '0;
    logic [31:0] BranchTargetE = '0;
    logic        PredTakenE = 1'b0;
    logic [31:0] PredTargetE = '0;
    logic        MispredE;
    logic [31:0] RedirectPCE;
`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] BrCountO, MispredCountO;
`endif

    always #5 clk = ~clk;

    branch_predictor #(.IDX_W(IDX_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PCF           (PCF),
        .PredTakenF    (PredTakenF),
        .PredTargetF   (PredTargetF),
        .ValidE        (ValidE),
        .BranchTypeE   (BranchTypeE),
        .BranchE       (BranchE),
        .PCE           (PCE),
        .BranchTargetE (BranchTargetE),
        .PredTakenE    (PredTakenE),
        .PredTargetE   (PredTargetE),
        .MispredE      (MispredE),
        .RedirectPCE   (RedirectPCE)
`ifdef BRANCH_PRED_STATS_EN
        ,
        .BrCountO      (BrCountO),
        .MispredCountO (MispredCountO)
`endif
    );

    typedef struct {
        logic        ptf;
        logic [31:0] ptgf;
        logic        mis;
        logic        chk_rpc;
        logic [31:0] rpc;
        logic [31:0] brc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the table as plain arrays, counters as integers 0..3.
    bit          mv   [NUM];
    logic [31:0] mtag [NUM];
    logic [31:0] mtgt [NUM];
    int          mctr [NUM];
    logic [31:0] m_brc, m_mc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 32'(NUM));
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return mv[idx_of(pc)] && (mtag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (mctr[idx_of(pc)] >= 2);
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NUM; i++) begin
            mv[i]   = 1'b0;
            mctr[i] = 1;
        end
        m_brc = '0;
        m_mc  = '0;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] bt, input logic be,
                        input logic [31:0] pce, input logic [31:0] bte,
                        input logic pte, input logic [31:0] ptge, input logic [31:0] pcf);
        exp_t e;
        bit   br, hit;
        int   i;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ValidE = v; BranchTypeE = bt; BranchE = be; PCE = pce;
        BranchTargetE = bte; PredTakenE = pte; PredTargetE = ptge; PCF = pcf;

        e.ptf  = m_taken(pcf);
        e.ptgf = e.ptf ? mtgt[idx_of(pcf)] : 32'h0;
        br = (bt != 3'(NOBRANCH));
        if (br && be && (!pte || ptge != bte)) begin
            e.mis = v; e.rpc = bte;
        end else begin
            e.mis = v && pte && (!br || !be); e.rpc = pce + 32'd4;
        end
        e.chk_rpc = v;
        e.brc = m_brc;
        e.mc  = m_mc;
        sb.push_back(e);

        if (v) begin
            if (br) m_brc = m_brc + 32'd1;
            if (e.mis) m_mc = m_mc + 32'd1;
            i   = idx_of(pce);
            hit = m_hit(pce);
            if (br && hit && be) begin
                mctr[i] = (mctr[i] == 3) ? 3 : mctr[i] + 1;
                mtgt[i] = bte;
            end else if (br && hit) begin
                mctr[i] = (mctr[i] == 0) ? 0 : mctr[i] - 1;
            end else if (br && be) begin
                mv[i] = 1'b1; mtag[i] = tag_of(pce); mtgt[i] = bte; mctr[i] = 2;
            end else if (!br && hit) begin
                mv[i] = 1'b0;
            end
        end
    endtask

    task automatic idle(input logic [31:0] pcf);
        step(1'b0, 3'(NOBRANCH), 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, pcf);
    endtask

    // Reset is asserted between edges; the clear must be visible before the next edge.
    task automatic do_reset(input logic [31:0] pcf);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        ValidE = 1'b0; BranchTypeE = 3'(NOBRANCH); BranchE = 1'b0; PCE = 32'h0;
        BranchTargetE = 32'h0; PredTakenE = 1'b0; PredTargetE = 32'h0; PCF = pcf;
        m_reset();
        e.ptf = 1'b0; e.ptgf = 32'h0; e.mis = 1'b0; e.chk_rpc = 1'b0; e.rpc = 32'h0;
        e.brc = 32'h0; e.mc = 32'h0;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp("PredTakenF", {31'd0, PredTakenF}, {31'd0, e.ptf});
            cmp("PredTargetF", PredTargetF, e.ptgf);
            cmp("MispredE", {31'd0, MispredE}, {31'd0, e.mis});
            if (e.chk_rpc) cmp("RedirectPCE", RedirectPCE, e.rpc);
`ifdef BRANCH_PRED_STATS_EN
            cmp("BrCountO", BrCountO, e.brc);
            cmp("MispredCountO", MispredCountO, e.mc);
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pce, pcf, bte, ptge;
        logic [2:0]  bt;
        logic        pte;
        m_reset();
        do_reset(32'h100);
        idle(32'h100);
        step(1, BR_BEQ, 1, 32'h100, 32'h80, 0, 32'h0,  32'h100);
        idle(32'h100);
        step(1, BR_BEQ, 1, 32'h100, 32'h80, 1, 32'h80, 32'h100);
        step(1, BR_BEQ, 1, 32'h100, 32'h80, 1, 32'h80, 32'h100);
        step(1, BR_BEQ, 0, 32'h100, 32'h80, 1, 32'h80, 32'h100);
        idle(32'h100);
        step(1, BR_BEQ, 0, 32'h100, 32'h80, 1, 32'h80, 32'h100);
        idle(32'h100);
        step(1, BR_BNE, 1, 32'h100, 32'h80, 0, 32'h0,  32'h100);
        step(1, NOBRANCH, 0, 32'h200, 32'h0, 1, 32'h80, 32'h100);
        idle(32'h100);
        step(1, NOBRANCH, 0, 32'h100, 32'h0, 1, 32'h80, 32'h100);
        idle(32'h100);
        step(1, BR_BLT, 1, 32'h100, 32'h80, 0, 32'h0,  32'h100);
        step(1, BR_BLT, 1, 32'h100, 32'h90, 1, 32'h80, 32'h100);
        idle(32'h100);
        step(0, BR_BGE, 0, 32'h100, 32'h90, 1, 32'h90, 32'h100);
        idle(32'h100);
        step(1, NOBRANCH, 0, 32'hFFFF_FFFC, 32'h0, 0, 32'h0, 32'h100);
        step(1, BR_BGEU, 0, 32'hFFFF_FFFC, 32'h10, 1, 32'h10, 32'hFFFF_FFFC);
        do_reset(32'h100);
        idle(32'h100);

        for (int n = 0; n < 2000; n++) begin
            pce = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            pcf = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 31) == 0) pce = 32'hFFFF_FFFC;
            bte = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
            bt  = ($urandom_range(0, 3) == 0) ? 3'(NOBRANCH) : 3'($urandom_range(1, 6));
            if ($urandom_range(0, 3) != 0) begin
                pte  = m_taken(pce);
                ptge = pte ? mtgt[idx_of(pce)] : 32'h0;
            end else begin
                pte  = 1'($urandom_range(0, 1));
                ptge = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
            end
            if ($urandom_range(0, 99) == 0) do_reset(pcf);
            else step(1'($urandom_range(0, 4) != 0), bt, 1'($urandom_range(0, 1)),
                      pce, bte, pte, ptge, pcf);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
